tlb_maint_ctrl: RTL and testbench
=================================

Name: tlb_maint_ctrl

Overview:
- Sequences TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) against the shared tlb_entry array used by the address-translation stage.
- Before touching the array, it holds new inst/data translations and waits for in-flight ones to drain.
- It then drives the TLB write/read/lookup ports and returns a single completion to the CSR/commit logic.
- INVTLB is executed as an entry-by-entry scan.

Parameters:
- TLBNUM, 16, number of TLB entries; power of 2, 4..64. IW = $clog2(TLBNUM).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- op_valid  in  1  maintenance request
- op_ready  out  1  high only in IDLE
- op_code  in  3  0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV; 5-7 are illegal
- inv_op  in  5  INVTLB op field
- inv_asid  in  10  INVTLB ASID operand
- inv_vppn  in  19  INVTLB VA[31:13]
- csr_index  in  IW  TLBIDX.Index
- csr_asid  in  10  ASID.ASID
- csr_vppn  in  19  TLBEHI.VPPN
- trans_hold  out  1  blocks new inst/data address acceptance
- trans_idle  in  1  both translation pipelines are empty
- srch_req  out  1  lookup strobe; lookup uses csr_vppn/csr_asid
- srch_found  in  1  lookup result, valid the cycle after srch_req
- srch_index  in  IW  lookup result, valid the cycle after srch_req
- tlb_we  out  1  full-entry write from CSR image
- tlb_w_index  out  IW  write index
- tlb_inv_we  out  1  clear E of entry tlb_r_index
- tlb_r_index  out  IW  read index
- r_e, r_g  in  1 each  entry E and G bits, combinational from tlb_r_index
- r_asid  in  10  entry ASID
- r_vppn  in  19  entry VPPN
- r_ps  in  6  entry page size
- done_valid  out  1  one-cycle completion pulse
- done_found  out  1  SRCH hit
- done_index  out  IW  SRCH hit index
- done_err  out  1  illegal op_code or inv_op

Behaviour:
- Reset values:
  - state=IDLE.
  - All strobes and done_* = 0; trans_hold=0.
  - tlb_w_index, tlb_r_index = 0; fill pointer = 0.
- Handshake:
  - Accept when op_valid && op_ready; latch op_code, inv_op, inv_asid, inv_vppn, csr_index.
  - Only one op is outstanding at a time.
- States: IDLE, DRAIN, SRCH, SRCH_W, RD, WR, INV_SCAN, DONE.
- IDLE → DRAIN on accept.
- trans_hold is 1 in every state except IDLE.
- DRAIN:
  - Wait until trans_idle=1.
  - Then branch: SRCH; RD; WR (op 2 or 3); INV_SCAN with scan counter=0 (op 4).
  - Illegal op_code, or op 4 with inv_op>6, goes to DONE with done_err=1 and no array access.
- SRCH: srch_req=1 for one cycle → SRCH_W.
- SRCH_W: register srch_found/srch_index into done_found/done_index → DONE.
- RD: tlb_r_index=csr_index for one cycle; the CSR block captures the r_* outputs that cycle → DONE.
- WR:
  - tlb_we=1 for one cycle → DONE.
  - tlb_w_index = latched csr_index for op 2; = fill pointer for op 3.
  - Fill pointer advances only on a FILL write, wrapping TLBNUM-1 → 0.
- INV_SCAN:
  - Each cycle: tlb_r_index = scan counter; tlb_inv_we = match.
  - Match requires r_e=1 and:
    - inv_op 0/1: always
    - inv_op 2: r_g
    - inv_op 3: !r_g
    - inv_op 4: !r_g && asid_eq
    - inv_op 5: !r_g && asid_eq && va_eq
    - inv_op 6: (r_g || asid_eq) && va_eq
  - asid_eq = (r_asid == inv_asid).
  - va_eq compares bits [18:9] always, and bits [8:0] only when r_ps != 21.
  - Counter increments each cycle; after index TLBNUM-1 → DONE. Scan takes exactly TLBNUM cycles.
- DONE: done_valid=1 for one cycle; trans_hold=0; → IDLE.
- done_found and done_index are 0 for non-SRCH ops.
- Latency from accept to done_valid, with trans_idle already 1:
  - SRCH: 4 cycles
  - RD, WR, FILL: 3 cycles
  - INV: TLBNUM+2 cycles
  - Illegal op: 2 cycles
- Pipeline flushes do not abort an accepted op.
- Reset mid-op returns to IDLE immediately; a partial INV scan is not resumed.
- tlb_we and tlb_inv_we are never high in the same cycle.

Optional Feature:
- Macro: TLB_FILL_LFSR_EN.
- When defined:
  - The fill pointer is the low IW bits of a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset).
  - The LFSR steps every clock, regardless of op.
- When undefined: round-robin fill pointer as described in Behaviour.

Test Plan:
- TLBWR, csr_index=5, trans_idle held 0 for 3 cycles then 1 → trans_hold high from the cycle after accept; tlb_we pulses once with tlb_w_index=5 in the cycle after trans_idle rises; done_valid follows, done_err=0.
- Three TLBFILLs back-to-back (no LFSR) → tlb_w_index = 0, 1, 2. With TLBNUM=16, the 17th FILL writes index 0.
- TLBSRCH with the model returning found=1, index=9 → done_found=1, done_index=9, 4 cycles after accept.
- INVTLB op 5, asid=3, vppn=0x1234; model entries: 2={E,G=0,asid 3,vppn 0x1234}, 7={E,G=1,same}, 11={E,G=0,asid 4,same} → tlb_inv_we asserted only when tlb_r_index=2; done_valid at cycle 18.
- INVTLB inv_op=9 → done_valid with done_err=1 two cycles after accept; no tlb_we or tlb_inv_we pulses.
- Reset asserted at scan index 6 of INVTLB op 0 → next cycle: op_ready=1, trans_hold=0, no further tlb_inv_we pulses.

Source files
------------

// File: rtl/tlb_maint_ctrl_if.sv
// Request/completion bundle between the CSR/commit logic (master) and tlb_maint_ctrl (slave).
interface tlb_maint_ctrl_if #(
  parameter int unsigned IW = 4
);
  logic          op_valid;
  logic          op_ready;
  logic [2:0]    op_code;
  logic [4:0]    inv_op;
  logic [9:0]    inv_asid;
  logic [18:0]   inv_vppn;
  logic [IW-1:0] csr_index;
  logic [9:0]    csr_asid;
  logic [18:0]   csr_vppn;
  logic          done_valid;
  logic          done_found;
  logic [IW-1:0] done_index;
  logic          done_err;

  modport master (
    output op_valid, op_code, inv_op, inv_asid, inv_vppn, csr_index, csr_asid, csr_vppn,
    input  op_ready, done_valid, done_found, done_index, done_err
  );

  modport slave (
    input  op_valid, op_code, inv_op, inv_asid, inv_vppn, csr_index, csr_asid, csr_vppn,
    output op_ready, done_valid, done_found, done_index, done_err
  );
endinterface

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: holds translation, waits for drain, then drives the tlb_entry ports.
// Define TLB_FILL_LFSR_EN to take the TLBFILL index from a free-running 16-bit LFSR.
module tlb_maint_ctrl #(
  parameter int unsigned TLBNUM = 16,
  localparam int unsigned IW = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  tlb_maint_ctrl_if.slave bus,
  output logic            trans_hold,
  input  logic            trans_idle,
  output logic            srch_req,
  input  logic            srch_found,
  input  logic [IW-1:0]   srch_index,
  output logic            tlb_we,
  output logic [IW-1:0]   tlb_w_index,
  output logic            tlb_inv_we,
  output logic [IW-1:0]   tlb_r_index,
  input  logic            r_e,
  input  logic            r_g,
  input  logic [9:0]      r_asid,
  input  logic [18:0]     r_vppn,
  input  logic [5:0]      r_ps
);

  typedef enum logic [2:0] {
    StIdle, StDrain, StSrch, StSrchW, StRd, StWr, StInvScan, StDone
  } state_e;

  localparam logic [2:0] OpSrch = 3'd0;
  localparam logic [2:0] OpRd   = 3'd1;
  localparam logic [2:0] OpWr   = 3'd2;
  localparam logic [2:0] OpFill = 3'd3;
  localparam logic [2:0] OpInv  = 3'd4;

  state_e        state_q, state_d;
  logic [2:0]    op_code_q, op_code_d;
  logic [4:0]    inv_op_q, inv_op_d;
  logic [9:0]    inv_asid_q, inv_asid_d;
  logic [18:0]   inv_vppn_q, inv_vppn_d;
  logic [IW-1:0] csr_index_q, csr_index_d;
  logic          trans_hold_q, trans_hold_d;
  logic          srch_req_q, srch_req_d;
  logic          tlb_we_q, tlb_we_d;
  logic [IW-1:0] tlb_w_index_q, tlb_w_index_d;
  logic [IW-1:0] tlb_r_index_q, tlb_r_index_d;
  logic          done_valid_q, done_valid_d;
  logic          done_found_q, done_found_d;
  logic [IW-1:0] done_index_q, done_index_d;
  logic          done_err_q, done_err_d;

  logic [IW-1:0] fill_ptr;
  logic          fill_adv;
  logic          illegal;
  logic          asid_eq, va_eq, inv_sel, inv_match;

  // The lookup itself consumes csr_asid/csr_vppn directly; nothing here needs them.
  logic unused_csr;
  assign unused_csr = ^{bus.csr_asid, bus.csr_vppn};

`ifdef TLB_FILL_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        unused_fill_adv;

  assign unused_fill_adv = fill_adv;
  assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign fill_ptr = lfsr_q[IW-1:0];

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
`else
  logic [IW-1:0] fill_ptr_q, fill_ptr_d;

  assign fill_ptr_d = fill_adv ? fill_ptr_q + IW'(1) : fill_ptr_q;
  assign fill_ptr   = fill_ptr_q;

  always_ff @(posedge clk) begin
    if (reset) fill_ptr_q <= '0;
    else       fill_ptr_q <= fill_ptr_d;
  end
`endif

  assign illegal = (op_code_q > OpInv) || ((op_code_q == OpInv) && (inv_op_q > 5'd6));

  // Huge (2^21) pages ignore the low VPPN bits.
  always_comb begin
    asid_eq = (r_asid == inv_asid_q);
    va_eq   = (r_vppn[18:9] == inv_vppn_q[18:9]) &&
              ((r_ps == 6'd21) || (r_vppn[8:0] == inv_vppn_q[8:0]));
    case (inv_op_q)
      5'd0, 5'd1: inv_sel = 1'b1;
      5'd2:       inv_sel = r_g;
      5'd3:       inv_sel = !r_g;
      5'd4:       inv_sel = !r_g && asid_eq;
      5'd5:       inv_sel = !r_g && asid_eq && va_eq;
      5'd6:       inv_sel = (r_g || asid_eq) && va_eq;
      default:    inv_sel = 1'b0;
    endcase
    inv_match = r_e && inv_sel;
  end

  always_comb begin
    state_d       = state_q;
    op_code_d     = op_code_q;
    inv_op_d      = inv_op_q;
    inv_asid_d    = inv_asid_q;
    inv_vppn_d    = inv_vppn_q;
    csr_index_d   = csr_index_q;
    srch_req_d    = 1'b0;
    tlb_we_d      = 1'b0;
    tlb_w_index_d = tlb_w_index_q;
    tlb_r_index_d = tlb_r_index_q;
    done_valid_d  = 1'b0;
    done_found_d  = 1'b0;
    done_index_d  = '0;
    done_err_d    = 1'b0;
    fill_adv      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.op_valid) begin
          op_code_d   = bus.op_code;
          inv_op_d    = bus.inv_op;
          inv_asid_d  = bus.inv_asid;
          inv_vppn_d  = bus.inv_vppn;
          csr_index_d = bus.csr_index;
          state_d     = StDrain;
        end
      end
      StDrain: begin
        if (trans_idle) begin
          if (illegal) begin
            state_d      = StDone;
            done_valid_d = 1'b1;
            done_err_d   = 1'b1;
          end else if (op_code_q == OpSrch) begin
            state_d    = StSrch;
            srch_req_d = 1'b1;
          end else if (op_code_q == OpRd) begin
            state_d       = StRd;
            tlb_r_index_d = csr_index_q;
          end else if ((op_code_q == OpWr) || (op_code_q == OpFill)) begin
            state_d       = StWr;
            tlb_we_d      = 1'b1;
            tlb_w_index_d = (op_code_q == OpFill) ? fill_ptr : csr_index_q;
          end else begin
            state_d       = StInvScan;
            tlb_r_index_d = '0;
          end
        end
      end
      StSrch: state_d = StSrchW;
      StSrchW: begin
        state_d      = StDone;
        done_valid_d = 1'b1;
        done_found_d = srch_found;
        done_index_d = srch_index;
      end
      StRd: begin
        state_d      = StDone;
        done_valid_d = 1'b1;
      end
      StWr: begin
        state_d      = StDone;
        done_valid_d = 1'b1;
        fill_adv     = (op_code_q == OpFill);
      end
      StInvScan: begin
        tlb_r_index_d = tlb_r_index_q + IW'(1);
        if (tlb_r_index_q == IW'(TLBNUM - 1)) begin
          state_d      = StDone;
          done_valid_d = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    trans_hold_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      op_code_q     <= '0;
      inv_op_q      <= '0;
      inv_asid_q    <= '0;
      inv_vppn_q    <= '0;
      csr_index_q   <= '0;
      trans_hold_q  <= 1'b0;
      srch_req_q    <= 1'b0;
      tlb_we_q      <= 1'b0;
      tlb_w_index_q <= '0;
      tlb_r_index_q <= '0;
      done_valid_q  <= 1'b0;
      done_found_q  <= 1'b0;
      done_index_q  <= '0;
      done_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_code_q     <= op_code_d;
      inv_op_q      <= inv_op_d;
      inv_asid_q    <= inv_asid_d;
      inv_vppn_q    <= inv_vppn_d;
      csr_index_q   <= csr_index_d;
      trans_hold_q  <= trans_hold_d;
      srch_req_q    <= srch_req_d;
      tlb_we_q      <= tlb_we_d;
      tlb_w_index_q <= tlb_w_index_d;
      tlb_r_index_q <= tlb_r_index_d;
      done_valid_q  <= done_valid_d;
      done_found_q  <= done_found_d;
      done_index_q  <= done_index_d;
      done_err_q    <= done_err_d;
    end
  end

  assign bus.op_ready   = (state_q == StIdle);
  assign bus.done_valid = done_valid_q;
  assign bus.done_found = done_found_q;
  assign bus.done_index = done_index_q;
  assign bus.done_err   = done_err_q;
  assign trans_hold     = trans_hold_q;
  assign srch_req       = srch_req_q;
  assign tlb_we         = tlb_we_q;
  assign tlb_w_index    = tlb_w_index_q;
  assign tlb_r_index    = tlb_r_index_q;
  // Invalidate depends on the entry read back this cycle, so it cannot be registered.
  assign tlb_inv_we     = (state_q == StInvScan) && inv_match;

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Scoreboard bench for tlb_maint_ctrl: static TLB model, lookup responder, completion monitor.
module tb_tlb_maint_ctrl;
  localparam int unsigned TLBNUM = 16;
  localparam int unsigned IW     = 4;
  localparam logic [2:0] OpSrch = 3'd0, OpRd = 3'd1, OpWr = 3'd2, OpFill = 3'd3, OpInv = 3'd4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tlb_maint_ctrl_if #(.IW(IW)) bus ();

  logic          trans_hold, trans_idle, srch_req, srch_found;
  logic [IW-1:0] srch_index;
  logic          tlb_we, tlb_inv_we;
  logic [IW-1:0] tlb_w_index, tlb_r_index;
  logic          r_e, r_g;
  logic [9:0]    r_asid;
  logic [18:0]   r_vppn;
  logic [5:0]    r_ps;

  tlb_maint_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .trans_hold (trans_hold),
    .trans_idle (trans_idle),
    .srch_req   (srch_req),
    .srch_found (srch_found),
    .srch_index (srch_index),
    .tlb_we     (tlb_we),
    .tlb_w_index(tlb_w_index),
    .tlb_inv_we (tlb_inv_we),
    .tlb_r_index(tlb_r_index),
    .r_e        (r_e),
    .r_g        (r_g),
    .r_asid     (r_asid),
    .r_vppn     (r_vppn),
    .r_ps       (r_ps)
  );

  // Static entry model read combinationally by index.
  logic        m_e    [TLBNUM];
  logic        m_g    [TLBNUM];
  logic [9:0]  m_asid [TLBNUM];
  logic [18:0] m_vppn [TLBNUM];
  logic [5:0]  m_ps   [TLBNUM];
  assign r_e    = m_e[tlb_r_index];
  assign r_g    = m_g[tlb_r_index];
  assign r_asid = m_asid[tlb_r_index];
  assign r_vppn = m_vppn[tlb_r_index];
  assign r_ps   = m_ps[tlb_r_index];

  logic          m_found;
  logic [IW-1:0] m_index;
  always @(posedge clk) begin
    srch_found <= srch_req & m_found;
    srch_index <= srch_req ? m_index : '0;
  end

  typedef struct {
    logic          found;
    logic [IW-1:0] index;
    logic          err;
    time           t;
  } done_t;

  done_t         sb_q[$];
  int            exp_we_q[$];
  logic [TLBNUM-1:0] inv_mask;
  int            total = 0;
  int            bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset == 1'b0) begin
      if (bus.done_valid) begin
        check_eq("done_expected", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          done_t e;
          e = sb_q.pop_front();
          check_eq("done_found", 64'(bus.done_found), 64'(e.found));
          check_eq("done_index", 64'(bus.done_index), 64'(e.index));
          check_eq("done_err", 64'(bus.done_err), 64'(e.err));
          check_eq("done_time", 64'($time), 64'(e.t));
        end
      end
      if (tlb_we) begin
        check_eq("we_expected", 64'(exp_we_q.size() != 0), 64'd1);
        if (exp_we_q.size() != 0) check_eq("w_index", 64'(tlb_w_index), 64'(exp_we_q.pop_front()));
      end
      if (tlb_we || tlb_inv_we) check_eq("we_excl", 64'(tlb_we & tlb_inv_we), 64'd0);
      if (tlb_inv_we) inv_mask[tlb_r_index] = 1'b1;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [4:0] iop, input logic [9:0] asid,
                       input logic [18:0] vppn, input logic [IW-1:0] idx, input logic efound,
                       input logic [IW-1:0] eindex, input logic eerr, input int lat,
                       input bit push_done, input int we_idx);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.op_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("op_ready", 64'(bus.op_ready), 64'd1);
    bus.op_valid  = 1'b1;
    bus.op_code   = op;
    bus.inv_op    = iop;
    bus.inv_asid  = asid;
    bus.inv_vppn  = vppn;
    bus.csr_index = idx;
    if (push_done) sb_q.push_back('{efound, eindex, eerr, $time + 64'(lat) * 10});
    if (we_idx >= 0) exp_we_q.push_back(we_idx);
    @(negedge clk);
    bus.op_valid = 1'b0;
  endtask

  task automatic drain_sb();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !bus.op_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    check_eq("we_drained", 64'(exp_we_q.size()), 64'd0);
  endtask

  task automatic run_inv(input logic [4:0] iop, input logic [9:0] asid, input logic [18:0] vppn,
                         input logic [TLBNUM-1:0] exp_mask, input string tag);
    inv_mask = '0;
    issue(OpInv, iop, asid, vppn, '0, 1'b0, '0, 1'b0, TLBNUM + 2, 1'b1, -1);
    drain_sb();
    check_eq(tag, 64'(inv_mask), 64'(exp_mask));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < TLBNUM; i++) begin
      m_e[i] = 1'b0; m_g[i] = 1'b0; m_asid[i] = '0; m_vppn[i] = '0; m_ps[i] = 6'd12;
    end
    m_e[2]  = 1'b1; m_g[2]  = 1'b0; m_asid[2]  = 10'd3; m_vppn[2]  = 19'h1234;
    m_e[4]  = 1'b0; m_g[4]  = 1'b1; m_asid[4]  = 10'd3; m_vppn[4]  = 19'h1234;
    m_e[7]  = 1'b1; m_g[7]  = 1'b1; m_asid[7]  = 10'd3; m_vppn[7]  = 19'h1234;
    m_e[11] = 1'b1; m_g[11] = 1'b0; m_asid[11] = 10'd4; m_vppn[11] = 19'h1234;
    m_e[13] = 1'b1; m_g[13] = 1'b0; m_asid[13] = 10'd3; m_vppn[13] = 19'h1200; m_ps[13] = 6'd21;
    m_found = 1'b0; m_index = '0;
    inv_mask = '0;
    bus.op_valid = 1'b0; bus.op_code = '0; bus.inv_op = '0; bus.inv_asid = '0;
    bus.inv_vppn = '0; bus.csr_index = '0; bus.csr_asid = 10'd3; bus.csr_vppn = 19'h1234;
    trans_idle = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check_eq("rst_op_ready", 64'(bus.op_ready), 64'd1);
    check_eq("rst_trans_hold", 64'(trans_hold), 64'd0);
    check_eq("rst_tlb_we", 64'(tlb_we), 64'd0);
    check_eq("rst_inv_we", 64'(tlb_inv_we), 64'd0);
    check_eq("rst_srch_req", 64'(srch_req), 64'd0);
    check_eq("rst_done_valid", 64'(bus.done_valid), 64'd0);
    check_eq("rst_done_err", 64'(bus.done_err), 64'd0);
    check_eq("rst_done_found", 64'(bus.done_found), 64'd0);
    check_eq("rst_done_index", 64'(bus.done_index), 64'd0);
    check_eq("rst_w_index", 64'(tlb_w_index), 64'd0);
    check_eq("rst_r_index", 64'(tlb_r_index), 64'd0);

    // TLBWR to 5 while translation takes three extra cycles to drain.
    trans_idle = 1'b0;
    issue(OpWr, '0, '0, '0, 4'd5, 1'b0, '0, 1'b0, 6, 1'b1, 5);
    check_eq("wr_hold", 64'(trans_hold), 64'd1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    check_eq("wr_we_early", 64'(tlb_we), 64'd0);
    trans_idle = 1'b1;
    @(negedge clk);
    check_eq("wr_we", 64'(tlb_we), 64'd1);
    check_eq("wr_idx", 64'(tlb_w_index), 64'd5);
    drain_sb();

    // 17 back-to-back fills: round-robin 0..15 then wraps to 0.
    for (int i = 0; i < 17; i++)
      issue(OpFill, '0, '0, '0, 4'd9, 1'b0, '0, 1'b0, 3, 1'b1, i % TLBNUM);
    drain_sb();

    m_found = 1'b1; m_index = 4'd9;
    issue(OpSrch, '0, '0, '0, '0, 1'b1, 4'd9, 1'b0, 4, 1'b1, -1);
    drain_sb();
    m_found = 1'b0; m_index = 4'd0;
    issue(OpSrch, '0, '0, '0, '0, 1'b0, 4'd0, 1'b0, 4, 1'b1, -1);
    drain_sb();

    issue(OpRd, '0, '0, '0, 4'd7, 1'b0, '0, 1'b0, 3, 1'b1, -1);
    @(negedge clk);
    check_eq("rd_r_index", 64'(tlb_r_index), 64'd7);
    drain_sb();

    run_inv(5'd5, 10'd3, 19'h1234, 16'h2004, "inv5_mask");
    run_inv(5'd2, 10'd3, 19'h1234, 16'h0080, "inv2_mask");
    run_inv(5'd3, 10'd3, 19'h1234, 16'h2804, "inv3_mask");
    run_inv(5'd4, 10'd4, 19'h1234, 16'h0800, "inv4_mask");
    run_inv(5'd6, 10'd3, 19'h1234, 16'h2084, "inv6_mask");
    run_inv(5'd6, 10'd3, 19'h1200, 16'h2000, "inv6_ps_mask");
    run_inv(5'd0, 10'd0, 19'h0, 16'h2884, "inv0_mask");

    inv_mask = '0;
    issue(OpInv, 5'd9, 10'd3, 19'h1234, '0, 1'b0, '0, 1'b1, 2, 1'b1, -1);
    drain_sb();
    issue(3'd6, '0, '0, '0, '0, 1'b0, '0, 1'b1, 2, 1'b1, -1);
    drain_sb();
    check_eq("illegal_no_inv", 64'(inv_mask), 64'd0);

    // Reset in the middle of an INVTLB op 0 scan.
    issue(OpInv, 5'd0, '0, '0, '0, 1'b0, '0, 1'b0, 0, 1'b0, -1);
    n = 0;
    while (!(trans_hold && tlb_r_index == 4'd6) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("scan_at_6", 64'(tlb_r_index), 64'd6);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_op_ready", 64'(bus.op_ready), 64'd1);
    check_eq("midrst_hold", 64'(trans_hold), 64'd0);
    check_eq("midrst_done", 64'(bus.done_valid), 64'd0);
    reset = 1'b0;
    inv_mask = '0;
    repeat (20) @(negedge clk);
    check_eq("midrst_no_inv", 64'(inv_mask), 64'd0);

    // Fill pointer sat at 1 before the reset; it must restart from 0.
    issue(OpFill, '0, '0, '0, '0, 1'b0, '0, 1'b0, 3, 1'b1, 0);
    drain_sb();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
